// File: rtl/isa_io_pkg.sv
// Shared types and widths for the SM2201 ISA I/O front end.
// Imported by isa_strobe_filter and isa_io_decoder.
package isa_io_pkg;

  localparam int ISA_ADDR_W = 10;
  localparam int WAIT_CNT_W = 8;
  localparam int FILT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    WAIT,
    HOLD
  } io_state_e;

endpackage

// File: rtl/isa_strobe_filter.sv
// Two-flop synchroniser plus glitch filter for one active-low ISA strobe.
// The output changes only after FILTER_CYCLES consecutive agreeing synchronised samples.
module isa_strobe_filter
  import isa_io_pkg::*;
#(
  parameter int FILTER_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_n_i,
  output logic active_o
);

  logic                  sync1_q;
  logic                  sync2_q;
  logic                  filt_n_q;
  logic [FILT_CNT_W-1:0] cnt_q;

  // NOTE: non-blocking assignments make sync1_q -> sync2_q a real two-stage shift;
  // blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      filt_n_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q <= strobe_n_i;
      sync2_q <= sync1_q;
      if (sync2_q == filt_n_q) begin
        cnt_q <= '0;
      end else if (cnt_q == FILT_CNT_W'(FILTER_CYCLES - 1)) begin
        filt_n_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign active_o = ~filt_n_q;

endmodule

// File: rtl/isa_io_decoder.sv
// ISA I/O window decoder and IOCHRDY wait-state generator for the SM2201 board.
// Optional wait timeout is compiled in when ISA_IO_TIMEOUT_EN is defined.
module isa_io_decoder
  import isa_io_pkg::*;
#(
  parameter logic [ISA_ADDR_W-1:0] BASE_ADDR     = 10'h300,
  parameter int                    FILTER_CYCLES = 2,
  parameter int                    WAIT_TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ISA_ADDR_W-1:0] isa_addr,
  input  logic                  aen,
  input  logic                  ior_n,
  input  logic                  iow_n,
  input  logic                  rdy,
  output logic                  sel,
  output logic [1:0]            a,
  output logic                  w,
  output logic                  iochrdy,
  output logic                  data_oe,
  output logic                  tout
);

  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 7) begin : g_bad_filter
    $error("isa_io_decoder: FILTER_CYCLES must be 1..7");
  end
  if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 255) begin : g_bad_timeout
    $error("isa_io_decoder: WAIT_TIMEOUT must be 1..255");
  end

  logic rd_act;
  logic wr_act;

  isa_strobe_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_rd_filter (
    .clk        (clk),
    .reset      (reset),
    .strobe_n_i (ior_n),
    .active_o   (rd_act)
  );

  isa_strobe_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_wr_filter (
    .clk        (clk),
    .reset      (reset),
    .strobe_n_i (iow_n),
    .active_o   (wr_act)
  );

  io_state_e state_q;
  logic      rd_prev_q;
  logic      wr_prev_q;
  logic      sel_q;
  logic [1:0] a_q;
  logic      w_q;
  logic      iochrdy_q;
  logic      data_oe_q;

  // A start needs a fresh edge on exactly one strobe, so releasing one of two
  // simultaneous strobes never looks like a new single-strobe access.
  logic in_window;
  logic start;
  logic cur_act;

  assign in_window = (isa_addr[ISA_ADDR_W-1:2] == BASE_ADDR[ISA_ADDR_W-1:2]);
  assign start     = in_window && !aen &&
                     ((rd_act && !rd_prev_q && !wr_act) ||
                      (wr_act && !wr_prev_q && !rd_act));
  assign cur_act   = w_q ? wr_act : rd_act;

`ifdef ISA_IO_TIMEOUT_EN
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(WAIT_TIMEOUT - 1);
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic                  tout_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_prev_q  <= 1'b0;
      wr_prev_q  <= 1'b0;
      sel_q      <= 1'b1;
      a_q        <= 2'd0;
      w_q        <= 1'b0;
      iochrdy_q  <= 1'b1;
      data_oe_q  <= 1'b0;
`ifdef ISA_IO_TIMEOUT_EN
      wait_cnt_q <= '0;
      tout_q     <= 1'b0;
`endif
    end else begin
      rd_prev_q <= rd_act;
      wr_prev_q <= wr_act;
`ifdef ISA_IO_TIMEOUT_EN
      tout_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= QUAL;
            a_q        <= isa_addr[1:0];
            w_q        <= wr_act;
            sel_q      <= 1'b0;
            iochrdy_q  <= 1'b0;
            data_oe_q  <= !wr_act;
`ifdef ISA_IO_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end
        end
        // QUAL is the first cycle of the wait; rdy already high releases here.
        QUAL, WAIT: begin
          if (!cur_act) begin
            state_q   <= IDLE;
            sel_q     <= 1'b1;
            iochrdy_q <= 1'b1;
            data_oe_q <= 1'b0;
          end else if (rdy) begin
            state_q   <= HOLD;
            iochrdy_q <= 1'b1;
          end
`ifdef ISA_IO_TIMEOUT_EN
          else if (wait_cnt_q == TIMEOUT_LAST) begin
            state_q   <= HOLD;
            iochrdy_q <= 1'b1;
            tout_q    <= 1'b1;
          end
`endif
          else begin
            state_q <= WAIT;
`ifdef ISA_IO_TIMEOUT_EN
            if (wait_cnt_q != '1) wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
          end
        end
        HOLD: begin
          if (!cur_act) begin
            state_q   <= IDLE;
            sel_q     <= 1'b1;
            data_oe_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel     = sel_q;
  assign a       = a_q;
  assign w       = w_q;
  assign iochrdy = iochrdy_q;
  assign data_oe = data_oe_q;
`ifdef ISA_IO_TIMEOUT_EN
  assign tout    = tout_q;
`else
  assign tout    = 1'b0;
`endif

endmodule

// File: tb/tb_isa_io_decoder.sv
// Directed self-checking bench for isa_io_decoder (FILTER_CYCLES=2, WAIT_TIMEOUT=8).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_isa_io_decoder;

  logic       clk;
  logic       reset;
  logic [9:0] isa_addr;
  logic       aen;
  logic       ior_n;
  logic       iow_n;
  logic       rdy;
  logic       sel;
  logic [1:0] a;
  logic       w;
  logic       iochrdy;
  logic       data_oe;
  logic       tout;

  int n_checks = 0;
  int n_fail   = 0;

  isa_io_decoder #(
    .BASE_ADDR     (10'h300),
    .FILTER_CYCLES (2),
    .WAIT_TIMEOUT  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .isa_addr (isa_addr),
    .aen      (aen),
    .ior_n    (ior_n),
    .iow_n    (iow_n),
    .rdy      (rdy),
    .sel      (sel),
    .a        (a),
    .w        (w),
    .iochrdy  (iochrdy),
    .data_oe  (data_oe),
    .tout     (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    repeat (6) tick();
  endtask

  // Drives an access that must be ignored and reports whether sel/iochrdy ever moved.
  task automatic ignored_access(input string tag, input logic [9:0] addr, input logic aen_v,
                                input logic both, input int hold);
    bit saw_sel = 0;
    bit saw_wait = 0;
    isa_addr = addr;
    aen      = aen_v;
    iow_n    = 1'b0;
    if (both) ior_n = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (!sel) saw_sel = 1;
      if (!iochrdy) saw_wait = 1;
    end
    iow_n = 1'b1;
    ior_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (!sel) saw_sel = 1;
      if (!iochrdy) saw_wait = 1;
    end
    aen = 1'b0;
    check({tag, "_sel"}, 32'(saw_sel), 32'd0);
    check({tag, "_iochrdy"}, 32'(saw_wait), 32'd0);
  endtask

  initial begin
    int low;
    int touts;

    reset    = 1'b1;
    isa_addr = 10'h000;
    aen      = 1'b0;
    ior_n    = 1'b1;
    iow_n    = 1'b1;
    rdy      = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_sel", 32'(sel), 32'd1);
    check("rst_a", 32'(a), 32'd0);
    check("rst_w", 32'(w), 32'd0);
    check("rst_iochrdy", 32'(iochrdy), 32'd1);
    check("rst_data_oe", 32'(data_oe), 32'd0);
    check("rst_tout", 32'(tout), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    idle_gap();

    // Write 0x302, rdy raised 10 cycles after sel falls.
    isa_addr = 10'h302;
    iow_n    = 1'b0;
    repeat (4) tick();
    check("wr_sel_edge4", 32'(sel), 32'd1);
    tick();
    check("wr_sel_edge5", 32'(sel), 32'd0);
    check("wr_iochrdy_edge5", 32'(iochrdy), 32'd0);
    check("wr_a", 32'(a), 32'd2);
    check("wr_w", 32'(w), 32'd1);
    check("wr_data_oe", 32'(data_oe), 32'd0);
    low = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!iochrdy) low++;
    end
    rdy = 1'b1;
    tick();
    check("wr_iochrdy_low_cycles", 32'(low), 32'd11);
    check("wr_iochrdy_released", 32'(iochrdy), 32'd1);
    check("wr_sel_hold", 32'(sel), 32'd0);
    check("wr_data_oe_hold", 32'(data_oe), 32'd0);
    iow_n = 1'b1;
    rdy   = 1'b0;
    repeat (4) tick();
    check("wr_sel_end_edge4", 32'(sel), 32'd0);
    tick();
    check("wr_sel_end_edge5", 32'(sel), 32'd1);
    check("wr_a_kept", 32'(a), 32'd2);
    check("wr_w_kept", 32'(w), 32'd1);
    idle_gap();

    // Read 0x301 with rdy already high: one wait cycle only.
    isa_addr = 10'h301;
    rdy      = 1'b1;
    ior_n    = 1'b0;
    repeat (5) tick();
    check("rd_sel", 32'(sel), 32'd0);
    check("rd_a", 32'(a), 32'd1);
    check("rd_w", 32'(w), 32'd0);
    check("rd_data_oe", 32'(data_oe), 32'd1);
    check("rd_iochrdy_low", 32'(iochrdy), 32'd0);
    tick();
    check("rd_iochrdy_one_cycle", 32'(iochrdy), 32'd1);
    check("rd_data_oe_hold", 32'(data_oe), 32'd1);
    ior_n = 1'b1;
    rdy   = 1'b0;
    repeat (5) tick();
    check("rd_sel_end", 32'(sel), 32'd1);
    check("rd_data_oe_end", 32'(data_oe), 32'd0);
    idle_gap();

    ignored_access("glitch_1cyc", 10'h300, 1'b0, 1'b0, 1);
    ignored_access("addr_304", 10'h304, 1'b0, 1'b0, 10);
    ignored_access("aen_high", 10'h300, 1'b1, 1'b0, 10);
    ignored_access("both_strobes", 10'h300, 1'b0, 1'b1, 10);

    // After the double strobe, a single read must still decode.
    isa_addr = 10'h300;
    rdy      = 1'b1;
    ior_n    = 1'b0;
    repeat (5) tick();
    check("after_both_sel", 32'(sel), 32'd0);
    check("after_both_a", 32'(a), 32'd0);
    check("after_both_data_oe", 32'(data_oe), 32'd1);
    ior_n = 1'b1;
    rdy   = 1'b0;
    idle_gap();
    check("after_both_sel_end", 32'(sel), 32'd1);

    // Write 0x300 with rdy held low.
    isa_addr = 10'h300;
    iow_n    = 1'b0;
    repeat (5) tick();
    check("long_sel", 32'(sel), 32'd0);
`ifdef ISA_IO_TIMEOUT_EN
    low   = 1;
    touts = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (tout) touts++;
      if (iochrdy) break;
      low++;
    end
    repeat (3) begin
      tick();
      if (tout) touts++;
    end
    check("to_iochrdy_low_cycles", 32'(low), 32'd8);
    check("to_tout_pulses", 32'(touts), 32'd1);
    check("to_sel_still_low", 32'(sel), 32'd0);
    check("to_iochrdy_high", 32'(iochrdy), 32'd1);
    iow_n = 1'b1;
    repeat (5) tick();
    check("to_sel_end", 32'(sel), 32'd1);
`else
    touts = 0;
    low   = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (tout) touts++;
      if (!iochrdy) low++;
    end
    check("nto_iochrdy_held", 32'(low), 32'd40);
    check("nto_tout_never", 32'(touts), 32'd0);
    iow_n = 1'b1;
    repeat (4) tick();
    check("abort_iochrdy_edge4", 32'(iochrdy), 32'd0);
    tick();
    check("abort_iochrdy_edge5", 32'(iochrdy), 32'd1);
    check("abort_sel_edge5", 32'(sel), 32'd1);
`endif
    idle_gap();

    // Reset asserted between clock edges while in WAIT.
    isa_addr = 10'h301;
    iow_n    = 1'b0;
    repeat (7) tick();
    check("pre_rst_iochrdy", 32'(iochrdy), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_sel", 32'(sel), 32'd1);
    check("async_rst_a", 32'(a), 32'd0);
    check("async_rst_w", 32'(w), 32'd0);
    check("async_rst_iochrdy", 32'(iochrdy), 32'd1);
    check("async_rst_data_oe", 32'(data_oe), 32'd0);
    iow_n = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    idle_gap();

    // Normal write to 0x303 after reset.
    isa_addr = 10'h303;
    iow_n    = 1'b0;
    repeat (5) tick();
    check("post_rst_sel", 32'(sel), 32'd0);
    check("post_rst_a", 32'(a), 32'd3);
    check("post_rst_w", 32'(w), 32'd1);
    repeat (2) tick();
    rdy = 1'b1;
    tick();
    check("post_rst_iochrdy", 32'(iochrdy), 32'd1);
    iow_n = 1'b1;
    rdy   = 1'b0;
    repeat (5) tick();
    check("post_rst_sel_end", 32'(sel), 32'd1);
    check("post_rst_a_kept", 32'(a), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
